// File: rtl/sub_shft_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake,
// divide-by-zero detection and optional two's-complement operands.
module sub_shft_div_seq #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] D,
    input  logic [W-1:0] d,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         dbz
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]  ONES_W   = {W{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_INIT = CW'(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    p_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    dmag_r;
    logic            qneg_r;
    logic            rneg_r;
    logic [W-1:0]    q_r;
    logic [W-1:0]    r_r;
    logic            dbz_r;
    logic            busy_r;
    logic            done_r;

    logic            dvd_neg_s;
    logic            dvs_neg_s;
    logic [W-1:0]    dvd_mag_s;
    logic [W-1:0]    dvs_mag_s;
    logic [W:0]      p_shift_s;
    logic [W-1:0]    p_next_s;
    logic [W-1:0]    a_next_s;
    logic            qbit_s;
    logic [W-1:0]    q_fin_s;
    logic [W-1:0]    r_fin_s;

    // Two's-complement negate, also used to restore result signs.
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Operand magnitudes and signs; the most negative value maps to 2^(W-1) as unsigned.
    always_comb begin
        dvd_neg_s = (SIGNED == 1'b1) && D[W-1];
        dvs_neg_s = (SIGNED == 1'b1) && d[W-1];
        if (dvd_neg_s) begin
            dvd_mag_s = neg_w(D);
        end else begin
            dvd_mag_s = D;
        end
        if (dvs_neg_s) begin
            dvs_mag_s = neg_w(d);
        end else begin
            dvs_mag_s = d;
        end
    end

    // One restoring step; the remainder always fits W bits once the trial subtract is settled.
    always_comb begin
        p_shift_s = {p_r, a_r[W-1]};
        if (p_shift_s >= {1'b0, dmag_r}) begin
            p_next_s = W'(p_shift_s - {1'b0, dmag_r});
            qbit_s   = 1'b1;
        end else begin
            p_next_s = p_shift_s[W-1:0];
            qbit_s   = 1'b0;
        end
        a_next_s = {a_r[W-2:0], qbit_s};
        if (qneg_r) begin
            q_fin_s = neg_w(a_next_s);
        end else begin
            q_fin_s = a_next_s;
        end
        if (rneg_r) begin
            r_fin_s = neg_w(p_next_s);
        end else begin
            r_fin_s = p_next_s;
        end
    end

    // Next-state logic; DONE behaves like IDLE for accepting a new request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    if (d == ZERO_W) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and result registers; results are written only on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= {CW{1'b0}};
            p_r    <= ZERO_W;
            a_r    <= ZERO_W;
            dmag_r <= ZERO_W;
            qneg_r <= 1'b0;
            rneg_r <= 1'b0;
            q_r    <= ZERO_W;
            r_r    <= ZERO_W;
            dbz_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == RUN);
            done_r <= (state_nxt_s == DONE);
            case (state_r)
                IDLE, DONE: begin
                    if (start && (d == ZERO_W)) begin
                        q_r   <= ONES_W;
                        r_r   <= D;
                        dbz_r <= 1'b1;
                    end else if (start) begin
                        p_r    <= ZERO_W;
                        a_r    <= dvd_mag_s;
                        dmag_r <= dvs_mag_s;
                        qneg_r <= dvd_neg_s ^ dvs_neg_s;
                        rneg_r <= dvd_neg_s;
                        cnt_r  <= CNT_INIT;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                RUN: begin
                    p_r   <= p_next_s;
                    a_r   <= a_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        q_r   <= q_fin_s;
                        r_r   <= r_fin_s;
                        dbz_r <= 1'b0;
                    end else begin
                        dbz_r <= dbz_r;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign q    = q_r;
    assign r    = r_r;
    assign dbz  = dbz_r;

endmodule

// File: tb/tb_sub_shft_div_seq.sv
// Table-driven bench for sub_shft_div_seq: unsigned and signed instances at W=8,
// plus hand-written sequences for start-while-busy, back-to-back and mid-run reset.
module tb_sub_shft_div_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_u, start_s;
    logic [7:0] D_u, d_u, D_s, d_s;
    logic       busy_u, done_u, dbz_u, busy_s, done_s, dbz_s;
    logic [7:0] q_u, r_u, q_s, r_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sub_shft_div_seq #(.W(8), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst), .start(start_u), .D(D_u), .d(d_u),
        .busy(busy_u), .done(done_u), .q(q_u), .r(r_u), .dbz(dbz_u)
    );

    sub_shft_div_seq #(.W(8), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_s), .D(D_s), .d(d_s),
        .busy(busy_s), .done(done_s), .q(q_s), .r(r_s), .dbz(dbz_s)
    );

    typedef struct {
        bit         sgn;
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] eq;
        logic [7:0] er;
        logic       edbz;
    } vec_t;

    vec_t vecs[15];

    function automatic logic f_done(bit s); return s ? done_s : done_u; endfunction
    function automatic logic f_busy(bit s); return s ? busy_s : busy_u; endfunction
    function automatic logic f_dbz(bit s);  return s ? dbz_s  : dbz_u;  endfunction
    function automatic logic [7:0] f_q(bit s); return s ? q_s : q_u; endfunction
    function automatic logic [7:0] f_r(bit s); return s ? r_s : r_u; endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request, scramble operands afterwards, wait (bounded) for done.
    task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_bad);
        @(negedge clk);
        if (s) begin start_s = 1'b1; D_s = a; d_s = b; end
        else   begin start_u = 1'b1; D_u = a; d_u = b; end
        @(posedge clk);
        @(negedge clk);
        start_u = 1'b0; start_s = 1'b0;
        D_u = ~a; d_u = ~b; D_s = ~a; d_s = ~b;
        lat = 0;
        busy_bad = 0;
        while (!f_done(s) && lat < 20) begin
            if (f_busy(s) !== (b != 8'd0)) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (f_busy(s) !== 1'b0) busy_bad++;
    endtask

    initial begin
        int lat, bb, gap, stable_bad, extra;

        vecs[0]  = '{1'b0, 8'd14,  8'd3,   8'd4,   8'd2,   1'b0};
        vecs[1]  = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
        vecs[2]  = '{1'b0, 8'd55,  8'd0,   8'hFF,  8'd55,  1'b1};
        vecs[3]  = '{1'b0, 8'd14,  8'd3,   8'd4,   8'd2,   1'b0};
        vecs[4]  = '{1'b0, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[5]  = '{1'b0, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[6]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[7]  = '{1'b0, 8'd5,   8'd10,  8'd0,   8'd5,   1'b0};
        vecs[8]  = '{1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0};
        vecs[9]  = '{1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0};
        vecs[10] = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0};
        vecs[11] = '{1'b1, 8'hF9,  8'hFE,  8'h03,  8'hFF,  1'b0};
        vecs[12] = '{1'b1, 8'h80,  8'h01,  8'h80,  8'h00,  1'b0};
        vecs[13] = '{1'b1, 8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0};
        vecs[14] = '{1'b1, 8'h64,  8'h00,  8'hFF,  8'h64,  1'b1};

        rst = 1'b0;
        start_u = 1'b0; start_s = 1'b0;
        D_u = 8'd0; d_u = 8'd0; D_s = 8'd0; d_s = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {busy_u, busy_s}, 2'b00);
        check("reset_done", {done_u, done_s}, 2'b00);
        check("reset_dbz",  {dbz_u, dbz_s},   2'b00);
        check("reset_qr",   {q_u, r_u, q_s, r_s}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, lat, bb);
            check($sformatf("v%0d_latency", i), lat, vecs[i].edbz ? 0 : 8);
            check($sformatf("v%0d_busy", i), bb, 0);
            check($sformatf("v%0d_q", i), f_q(vecs[i].sgn), vecs[i].eq);
            check($sformatf("v%0d_r", i), f_r(vecs[i].sgn), vecs[i].er);
            check($sformatf("v%0d_dbz", i), f_dbz(vecs[i].sgn), vecs[i].edbz);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), f_done(vecs[i].sgn), 1'b0);
        end

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start_u = 1'b1; D_u = 8'd255; d_u = 8'd255;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!done_u && lat < 20) begin @(negedge clk); lat++; end
        check("b2b_first_latency", lat, 8);
        check("b2b_first_qr", {q_u, r_u}, {8'd1, 8'd0});
        D_u = 8'd0; d_u = 8'd5;
        @(posedge clk);
        @(negedge clk);
        start_u = 1'b0;
        check("b2b_rearm_busy", busy_u, 1'b1);
        gap = 1; stable_bad = 0;
        while (!done_u && gap < 20) begin
            if (q_u !== 8'd1 || r_u !== 8'd0) stable_bad++;
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", gap, 9);
        check("b2b_hold", stable_bad, 0);
        check("b2b_second_qr", {q_u, r_u}, {8'd0, 8'd0});

        // Start while busy is ignored.
        repeat (2) @(negedge clk);
        start_u = 1'b1; D_u = 8'd100; d_u = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start_u = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        start_u = 1'b1; D_u = 8'd3; d_u = 8'd1;
        @(posedge clk);
        @(negedge clk);
        start_u = 1'b0;
        lat = 4;
        while (!done_u && lat < 20) begin @(negedge clk); lat++; end
        check("ignore_latency", lat, 8);
        check("ignore_qr", {q_u, r_u}, {8'd11, 8'd1});
        extra = 0;
        repeat (15) begin @(negedge clk); if (done_u) extra++; end
        check("ignore_no_second_done", extra, 0);
        check("ignore_hold_qr", {q_u, r_u}, {8'd11, 8'd1});

        // Reset mid-run, applied between clock edges.
        @(negedge clk);
        start_u = 1'b1; D_u = 8'd200; d_u = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start_u = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        #1 rst = 1'b0;
        #1;
        check("rst_async_flags", {busy_u, done_u, dbz_u, dbz_s}, 4'b0000);
        check("rst_async_qr", {q_u, r_u, q_s, r_s}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (10) begin @(negedge clk); if (done_u || busy_u) extra++; end
        check("rst_no_stale_done", extra, 0);
        run_op(1'b0, 8'd14, 8'd3, lat, bb);
        check("rst_after_latency", lat, 8);
        check("rst_after_busy", bb, 0);
        check("rst_after_qr", {q_u, r_u, 7'd0, dbz_u}, {8'd4, 8'd2, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
